// File: rtl/mem_latency_responder_pkg.sv
// Shared types and constants for the latency-modelling data-memory responder.
// Build option: define MEM_RESP_ALIGN_CHECK_EN to report misaligned HALF/WORD accesses.
package mem_latency_responder_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 3;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_IDLE      = 3'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_BUSY      = 3'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READY     = 3'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_ERR_RANGE = 3'd3;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_ERR_ALIGN = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]      addr;
    logic [WORD_W-1:0]      wr_data;
    logic                   wr_en;
    logic [MEM_COUNT_W-1:0] count;
  } req_t;

  // Range takes priority over alignment when both flags are set.
  function automatic logic [MEM_CODE_W-1:0] resp_code(state_e st, logic err_range,
                                                     logic err_align);
    logic [MEM_CODE_W-1:0] code;
    code = MEM_CODE_IDLE;
    case (st)
      ST_WAIT: code = MEM_CODE_BUSY;
      ST_RESP: code = err_range ? MEM_CODE_ERR_RANGE :
                      err_align ? MEM_CODE_ERR_ALIGN : MEM_CODE_READY;
      default: code = MEM_CODE_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mem_latency_responder_if.sv
// Request/response bundle between the pipeline (master) and the memory responder (slave).
interface mem_latency_responder_if;
  import mem_latency_responder_pkg::*;

  // Handshake: a request is valid whenever i_req_count != NONE and is taken only while
  // o_res_code == IDLE; the response is valid for exactly one cycle when o_res_code is
  // READY, ERR_RANGE or ERR_ALIGN, and BUSY means the request is still in flight.
  logic [ADDR_W-1:0]      i_req_addr;
  logic [WORD_W-1:0]      i_req_wr_data;
  logic                   i_req_wr_en;
  logic [MEM_COUNT_W-1:0] i_req_count;
  logic [WORD_W-1:0]      o_res_rd_data;
  logic [MEM_CODE_W-1:0]  o_res_code;

  modport master (
    output i_req_addr, i_req_wr_data, i_req_wr_en, i_req_count,
    input  o_res_rd_data, o_res_code
  );

  modport slave (
    input  i_req_addr, i_req_wr_data, i_req_wr_en, i_req_count,
    output o_res_rd_data, o_res_code
  );
endinterface

// File: rtl/mem_lane_merge.sv
// Byte-lane extraction for reads and lane merge for writes on one 32-bit word.
module mem_lane_merge
  import mem_latency_responder_pkg::*;
(
  input  logic [MEM_COUNT_W-1:0] i_count,
  input  logic [1:0]             i_offset,
  input  logic [WORD_W-1:0]      i_old_word,
  input  logic [WORD_W-1:0]      i_wr_data,
  output logic [WORD_W-1:0]      o_rd_value,
  output logic [WORD_W-1:0]      o_new_word
);

  logic [4:0] w_byte_base;
  logic [4:0] w_half_base;

  // HALF selects its lane pair from offset[1] only; offset[0] never moves it.
  assign w_byte_base = {i_offset, 3'b000};
  assign w_half_base = {i_offset[1], 4'b0000};

  always_comb begin
    o_rd_value = '0;
    o_new_word = i_old_word;
    case (i_count)
      MEM_COUNT_BYTE: begin
        o_rd_value[7:0]             = i_old_word[w_byte_base +: 8];
        o_new_word[w_byte_base +: 8] = i_wr_data[7:0];
      end
      MEM_COUNT_HALF: begin
        o_rd_value[15:0]              = i_old_word[w_half_base +: 16];
        o_new_word[w_half_base +: 16] = i_wr_data[15:0];
      end
      MEM_COUNT_WORD: begin
        o_rd_value = i_old_word;
        o_new_word = i_wr_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_latency_responder.sv
// Data-memory responder with programmable latency; one request in flight at a time.
// Build option: MEM_RESP_ALIGN_CHECK_EN enables ERR_ALIGN for misaligned HALF/WORD.
module mem_latency_responder
  import mem_latency_responder_pkg::*;
#(
  parameter int WORD_COUNT = 16,
  parameter int LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    aresetn,
  mem_latency_responder_if.slave  bus,
  output state_e                  o_dbg_state
);

  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam int IDX_W = (WORD_COUNT < 2) ? 1 : $clog2(WORD_COUNT);
  localparam logic [ADDR_W-1:0] WC = ADDR_W'(WORD_COUNT);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  req_t              r_req;
  logic              r_err_range;
  logic              r_err_align;
  logic [WORD_W-1:0] r_rd_data;
  logic [WORD_W-1:0] r_mem [WORD_COUNT];

  req_t              w_in;
  req_t              w_src;
  logic              w_fire;
  logic              w_in_range;
  logic              w_align_err;
  logic [IDX_W-1:0]  w_idx;
  logic [WORD_W-1:0] w_old_word;
  logic [WORD_W-1:0] w_rd_value;
  logic [WORD_W-1:0] w_new_word;

  assign w_in = '{addr: bus.i_req_addr, wr_data: bus.i_req_wr_data,
                  wr_en: bus.i_req_wr_en, count: bus.i_req_count};

  // With LATENCY==1 the access happens on the accept edge, so it uses the live inputs.
  assign w_src  = (r_state == ST_IDLE) ? w_in : r_req;
  assign w_fire = ((r_state == ST_IDLE) && (LATENCY == 1) && (w_in.count != MEM_COUNT_NONE)) ||
                  ((r_state == ST_WAIT) && (r_cnt == CNT_W'(1)));

  assign w_in_range = ({2'b00, w_src.addr[ADDR_W-1:2]} < WC);
  assign w_idx      = w_src.addr[IDX_W+1:2];
  assign w_old_word = w_in_range ? r_mem[w_idx] : '0;

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign w_align_err = ((w_src.count == MEM_COUNT_HALF) && w_src.addr[0]) ||
                       ((w_src.count == MEM_COUNT_WORD) && (w_src.addr[1:0] != 2'b00));
`else
  assign w_align_err = 1'b0;
`endif

  mem_lane_merge u_lane_merge (
    .i_count    (w_src.count),
    .i_offset   (w_src.addr[1:0]),
    .i_old_word (w_old_word),
    .i_wr_data  (w_src.wr_data),
    .o_rd_value (w_rd_value),
    .o_new_word (w_new_word)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_in.count != MEM_COUNT_NONE) begin
            r_req   <= w_in;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_state <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= ST_RESP;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Access and error flags resolve together on the edge that enters RESP.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_err_range <= 1'b0;
      r_err_align <= 1'b0;
      r_rd_data   <= '0;
      for (int i = 0; i < WORD_COUNT; i++) r_mem[i] <= '0;
    end else if (w_fire) begin
      r_err_range <= !w_in_range;
      r_err_align <= w_in_range && w_align_err;
      if (w_in_range && !w_align_err) begin
        if (w_src.wr_en) r_mem[w_idx] <= w_new_word;
        else             r_rd_data    <= w_rd_value;
      end
    end
  end

  assign bus.o_res_rd_data = r_rd_data;
  assign bus.o_res_code    = resp_code(r_state, r_err_range, r_err_align);
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_mem_latency_responder.sv
// Directed bench for mem_latency_responder at WORD_COUNT=16, LATENCY=3.
module tb_mem_latency_responder;
  import mem_latency_responder_pkg::*;

  localparam int LAT = 3;

  logic   clk;
  logic   aresetn;
  state_e dbg_state;
  int     n_checks;
  int     n_errors;

  mem_latency_responder_if bus ();

  mem_latency_responder #(.WORD_COUNT(16), .LATENCY(LAT)) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_none();
    bus.i_req_addr    = '0;
    bus.i_req_wr_data = '0;
    bus.i_req_wr_en   = 1'b0;
    bus.i_req_count   = MEM_COUNT_NONE;
  endtask

  // One full transaction; junk (a WORD write to 0x3C) is presented while the request is in flight.
  task automatic run_req(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic we, input logic [1:0] cnt,
                         input logic [2:0] exp_code, input logic [31:0] exp_rd);
    @(negedge clk);
    check({tag, "_pre_idle"}, 32'(bus.o_res_code), 32'(MEM_CODE_IDLE));
    bus.i_req_addr    = addr;
    bus.i_req_wr_data = data;
    bus.i_req_wr_en   = we;
    bus.i_req_count   = cnt;
    @(posedge clk);
    #1;
    bus.i_req_addr    = 32'h0000_003C;
    bus.i_req_wr_data = 32'hFFFF_FFFF;
    bus.i_req_wr_en   = 1'b1;
    bus.i_req_count   = MEM_COUNT_WORD;
    for (int i = 0; i < LAT - 1; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, 32'(bus.o_res_code), 32'(MEM_CODE_BUSY));
    end
    @(negedge clk);
    check({tag, "_code"}, 32'(bus.o_res_code), 32'(exp_code));
    check({tag, "_rd"}, bus.o_res_rd_data, exp_rd);
    drive_none();
    @(negedge clk);
    check({tag, "_post_idle"}, 32'(bus.o_res_code), 32'(MEM_CODE_IDLE));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive_none();
    aresetn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_code", 32'(bus.o_res_code), 32'(MEM_CODE_IDLE));
    check("rst_rd", bus.o_res_rd_data, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    aresetn = 1'b1;

    run_req("wr_word8",   32'h08, 32'hDEAD_BEEF, 1'b1, MEM_COUNT_WORD, MEM_CODE_READY, 32'h0);
    run_req("rd_word8",   32'h08, 32'h0,         1'b0, MEM_COUNT_WORD, MEM_CODE_READY, 32'hDEAD_BEEF);
    run_req("wr_byte9",   32'h09, 32'hAAAA_AA55, 1'b1, MEM_COUNT_BYTE, MEM_CODE_READY, 32'hDEAD_BEEF);
    run_req("rd_merged",  32'h08, 32'h0,         1'b0, MEM_COUNT_WORD, MEM_CODE_READY, 32'hDEAD_55EF);
    run_req("rd_halfA",   32'h0A, 32'h0,         1'b0, MEM_COUNT_HALF, MEM_CODE_READY, 32'h0000_DEAD);
    run_req("rd_byteB",   32'h0B, 32'h0,         1'b0, MEM_COUNT_BYTE, MEM_CODE_READY, 32'h0000_00DE);
    run_req("rd_byte8",   32'h08, 32'h0,         1'b0, MEM_COUNT_BYTE, MEM_CODE_READY, 32'h0000_00EF);
    run_req("rd_range",   32'h40, 32'h0,         1'b0, MEM_COUNT_WORD, MEM_CODE_ERR_RANGE, 32'h0000_00EF);
    run_req("wr_range",   32'h40, 32'h1111_1111, 1'b1, MEM_COUNT_WORD, MEM_CODE_ERR_RANGE, 32'h0000_00EF);
    run_req("rd_word0",   32'h00, 32'h0,         1'b0, MEM_COUNT_WORD, MEM_CODE_READY, 32'h0);
`ifdef MEM_RESP_ALIGN_CHECK_EN
    run_req("wr_half5",   32'h05, 32'hFFFF_1234, 1'b1, MEM_COUNT_HALF, MEM_CODE_ERR_ALIGN, 32'h0);
    run_req("rd_word4",   32'h04, 32'h0,         1'b0, MEM_COUNT_WORD, MEM_CODE_READY, 32'h0);
    run_req("rd_word6",   32'h06, 32'h0,         1'b0, MEM_COUNT_WORD, MEM_CODE_ERR_ALIGN, 32'h0);
`else
    run_req("wr_half5",   32'h05, 32'hFFFF_1234, 1'b1, MEM_COUNT_HALF, MEM_CODE_READY, 32'h0);
    run_req("rd_word4",   32'h04, 32'h0,         1'b0, MEM_COUNT_WORD, MEM_CODE_READY, 32'h0000_1234);
    run_req("rd_word6",   32'h06, 32'h0,         1'b0, MEM_COUNT_WORD, MEM_CODE_READY, 32'h0000_1234);
`endif
    // junk writes to 0x3C during every WAIT must never have landed
    run_req("rd_word3C",  32'h3C, 32'h0,         1'b0, MEM_COUNT_WORD, MEM_CODE_READY, 32'h0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("none_idle", 32'(bus.o_res_code), 32'(MEM_CODE_IDLE));
    end

    // reset during WAIT of a write
    @(negedge clk);
    bus.i_req_addr    = 32'h10;
    bus.i_req_wr_data = 32'hCAFE_F00D;
    bus.i_req_wr_en   = 1'b1;
    bus.i_req_count   = MEM_COUNT_WORD;
    @(posedge clk);
    #1;
    drive_none();
    @(negedge clk);
    check("midrst_busy", 32'(bus.o_res_code), 32'(MEM_CODE_BUSY));
    aresetn = 1'b0;
    #1;
    check("midrst_code", 32'(bus.o_res_code), 32'(MEM_CODE_IDLE));
    check("midrst_rd", bus.o_res_rd_data, 32'h0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    aresetn = 1'b1;
    run_req("rd_after_rst10", 32'h10, 32'h0, 1'b0, MEM_COUNT_WORD, MEM_CODE_READY, 32'h0);
    run_req("rd_after_rst8",  32'h08, 32'h0, 1'b0, MEM_COUNT_WORD, MEM_CODE_READY, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_latency_responder.md
Name: mem_latency_responder

Overview:
- Responder end of the pipeline data-memory request interface.
- Accepts one request at a time from the pipeline (addr, wr_data, wr_en, count).
- Services it against an internal word array after a programmable number of wait cycles, then returns read data and a completion code.
- Used in benches and SoC builds to exercise pipeline stall handling under memory latency. Drop-in at the same port boundary as the data memory.

Parameters:
- WORD_COUNT, 16: number of 32-bit words in the backing array.
- LATENCY, 2: cycles from accept to the response cycle. Legal values are 1 or more; 1 means the response appears in the cycle after accept.

Ports:
- clk  in  1  rising-edge clock.
- aresetn  in  1  asynchronous active-low reset.
- i_req_addr  in  `ADDR_W  byte address.
- i_req_wr_data  in  `WORD_W  write data, right-aligned for sub-word writes.
- i_req_wr_en  in  1  1 = write, 0 = read.
- i_req_count  in  `MEM_COUNT_W  access size: MEM_COUNT_NONE=0, BYTE=1, HALF=2, WORD=3. NONE means no request.
- o_res_rd_data  out  `WORD_W  read data, zero-extended and right-aligned.
- o_res_code  out  `MEM_CODE_W  response code: MEM_CODE_IDLE, MEM_CODE_BUSY, MEM_CODE_READY, MEM_CODE_ERR_RANGE, MEM_CODE_ERR_ALIGN.

Behaviour:
- Clock and reset: one clock, clk. aresetn is asynchronous and active-low.
- State on reset: state=IDLE, counter=0, latched request cleared, all array words 0, o_res_rd_data=0, o_res_code=MEM_CODE_IDLE.
- Reset asserted mid-operation aborts the request. No write is performed and no response is issued.
- States:
  - IDLE: code IDLE. If i_req_count!=NONE, latch addr, wr_data, wr_en and count, and load counter=LATENCY-1. Go to RESP if LATENCY==1, else to WAIT.
  - WAIT: code BUSY. Counter decrements each cycle. When counter==1, go to RESP on the next edge. Inputs are ignored.
  - RESP: exactly one cycle. Code is READY, ERR_RANGE or ERR_ALIGN; the access and error are evaluated on the edge entering RESP. Always returns to IDLE.
- Requests are accepted only in IDLE. Inputs presented in WAIT or RESP are ignored. No back-to-back accept out of RESP: the minimum request spacing is LATENCY+1 cycles.
- Requester protocol: the requester must present NONE, or a new request, in the cycle after it sees a non-BUSY, non-IDLE code.
- Addressing: word index = addr[`ADDR_W-1:2], byte offset = addr[1:0].
- Range check: index >= WORD_COUNT gives ERR_RANGE. No write occurs and o_res_rd_data is unchanged. Range takes priority over alignment.
- Read: the selected lanes are shifted to bit 0 and zero-extended.
  - BYTE: lane = offset.
  - HALF: lanes offset[1]*2 and offset[1]*2+1.
  - WORD: full word.
- Write: only the addressed lanes are merged from the low bits of wr_data. All other lanes keep their value.
- o_res_rd_data updates only on a successful read completion and holds otherwise, including across writes.
- The response code is combinational from state plus a registered error flag.

Optional Feature:
- Macro: MEM_RESP_ALIGN_CHECK_EN.
- Defined: HALF with addr[0]=1, or WORD with addr[1:0]!=0, gives ERR_ALIGN. No write occurs and rd_data is unchanged.
- Undefined: no alignment errors. WORD ignores addr[1:0]. HALF ignores addr[0] and uses addr[1]. BYTE is unaffected.

Decomposition:
- mem_codes.vh holds the shared constants: MEM_CODE_* values, MEM_CODE_W, MEM_COUNT_* values and MEM_COUNT_W. config.vh holds ADDR_W and WORD_W.
- One combinational sub-module, mem_lane_merge, does sub-word extraction for reads and byte-enable merging for writes. It takes count, offset, old word and wr_data, and outputs rd_value and new_word.
- The FSM, counter and array stay in mem_latency_responder.

Test Plan:
- LATENCY=3: write WORD 0xDEADBEEF to 0x8 in IDLE -> code BUSY for 2 cycles, then READY for 1 cycle, then IDLE. A WORD read of 0x8 -> rd_data=0xDEADBEEF on its READY cycle.
- Byte merge: after the write above, write BYTE 0x55 at 0x9 -> a WORD read of 0x8 returns 0xDEAD55EF. A HALF read at 0xA returns 0x0000DEAD.
- Range: with WORD_COUNT=16, read WORD at 0x40 -> ERR_RANGE. rd_data keeps its previous value and the array is unchanged.
- Alignment, macro defined: HALF write at 0x5 -> ERR_ALIGN and no write. Macro undefined: the same request writes lanes 0-1 of word 1.
- Ignored inputs: change addr and count during WAIT -> the response reflects the latched request. count=NONE in IDLE -> stays IDLE indefinitely.
- Reset mid-operation: assert aresetn low during WAIT of a write -> code IDLE immediately and rd_data=0. After release, a read of that address returns 0.
